// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Holds the 5-bit opcode values found in ir[31:27], the instruction-class
// encoding produced by cu_opcode_class, and the sequencer state list.
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_RR, CLS_ALU_IMM, CLS_MULDIV, CLS_BR,
        CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
    } instr_class_e;

    typedef enum logic [5:0] {
        S_RESET, S_HALTED, S_T0, S_T1, S_T2,
        S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
        S_LDI_T3, S_LDI_T4, S_LDI_T5,
        S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
        S_ALU_T3, S_ALU_T4, S_ALU_T5,
        S_IMM_T3, S_IMM_T4, S_IMM_T5,
        S_MD_T3, S_MD_T4, S_MD_T5, S_MD_T6,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
        S_JR_T3, S_IN_T3, S_OUT_T3, S_MFHI_T3, S_MFLO_T3
    } state_e;

endpackage

// File: rtl/cu_opcode_class.sv
// Combinational opcode-to-class decoder for the control sequencer.
// Ports: opcode (in, 5) = ir[31:27]; op_class (out) = instruction class.
// Opcodes without a defined micro-sequence decode as CLS_NOP.
module cu_opcode_class
    import cu_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_e op_class
);

    // Opcode lookup; the default arm folds every undefined opcode into NOP.
    always_comb begin
        op_class = CLS_NOP;
        case (opcode)
            OP_LD:                          op_class = CLS_LD;
            OP_LDI:                         op_class = CLS_LDI;
            OP_ST:                          op_class = CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  op_class = CLS_ALU_RR;
            OP_ADDI, OP_ANDI, OP_ORI:       op_class = CLS_ALU_IMM;
            OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
            OP_BR:                          op_class = CLS_BR;
            OP_JR:                          op_class = CLS_JR;
            OP_IN:                          op_class = CLS_IN;
            OP_OUT:                         op_class = CLS_OUT;
            OP_MFHI:                        op_class = CLS_MFHI;
            OP_MFLO:                        op_class = CLS_MFLO;
            OP_HALT:                        op_class = CLS_HALT;
            default:                        op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Datapath: fetch (T0-T2), then a per-class
// micro-step sequence from T3 on, one step per clock.
// Ports: clk, clr (sync active-high reset), ir (instruction register),
// con_ff (branch condition); outputs: run, pc_init (= RESET_PC) and every
// Datapath bus-driver select, load enable and ALU/memory/register control.
// Optional build macro CU_MEM_WAIT_EN adds input mem_ready: T1, LD_T6 and
// ST_T7 then stretch until mem_ready is high.
// Outputs are a Moore function of the state register (con_ff only in BR_T6).
module control_sequencer
    import cu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
)(
    input  logic        clk,
    input  logic        clr,
`ifdef CU_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        run,
    output logic [31:0] pc_init,
    output logic        pc_init_enable, pc_out, zlo_out, zhi_out, hi_out, lo_out,
    output logic        mdr_out, inport_out, c_sign_extended_out, ba_out, r_out,
    output logic        mar_enable, z_enable, lo_enable, hi_enable, pc_enable,
    output logic        mdr_enable, ir_enable, y_enable, outport_enable,
    output logic        inport_enable, con_enable, r_in,
    output logic        pc_increment, read, ram_write, gra, grb, grc
);

    state_e       state_q, state_d;
    instr_class_e op_class_s;
    logic         mem_ready_s;
    logic         unused_ir_s;

`ifdef CU_MEM_WAIT_EN
    assign mem_ready_s = mem_ready;
`else
    assign mem_ready_s = 1'b1;
`endif

    // Only the opcode field steers the sequence; the rest of ir is ignored.
    assign unused_ir_s = ^ir[26:0];
    assign pc_init     = RESET_PC;

    cu_opcode_class u_class (
        .opcode   (ir[31:27]),
        .op_class (op_class_s)
    );

    // State register; clr forces RESET from any state, including mid-instruction.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The class is chosen while in T2 so that a nop costs
    // exactly three cycles and the first class step follows T2 directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:   state_d = S_T0;
            S_HALTED:  state_d = S_HALTED;
            S_T0:      state_d = S_T1;
            S_T1:      state_d = mem_ready_s ? S_T2 : S_T1;
            S_T2: begin
                case (op_class_s)
                    CLS_LD:      state_d = S_LD_T3;
                    CLS_LDI:     state_d = S_LDI_T3;
                    CLS_ST:      state_d = S_ST_T3;
                    CLS_ALU_RR:  state_d = S_ALU_T3;
                    CLS_ALU_IMM: state_d = S_IMM_T3;
                    CLS_MULDIV:  state_d = S_MD_T3;
                    CLS_BR:      state_d = S_BR_T3;
                    CLS_JR:      state_d = S_JR_T3;
                    CLS_IN:      state_d = S_IN_T3;
                    CLS_OUT:     state_d = S_OUT_T3;
                    CLS_MFHI:    state_d = S_MFHI_T3;
                    CLS_MFLO:    state_d = S_MFLO_T3;
                    CLS_HALT:    state_d = S_HALTED;
                    default:     state_d = S_T0;
                endcase
            end
            S_LD_T3:   state_d = S_LD_T4;
            S_LD_T4:   state_d = S_LD_T5;
            S_LD_T5:   state_d = S_LD_T6;
            S_LD_T6:   state_d = mem_ready_s ? S_LD_T7 : S_LD_T6;
            S_LDI_T3:  state_d = S_LDI_T4;
            S_LDI_T4:  state_d = S_LDI_T5;
            S_ST_T3:   state_d = S_ST_T4;
            S_ST_T4:   state_d = S_ST_T5;
            S_ST_T5:   state_d = S_ST_T6;
            S_ST_T6:   state_d = S_ST_T7;
            S_ST_T7:   state_d = mem_ready_s ? S_T0 : S_ST_T7;
            S_ALU_T3:  state_d = S_ALU_T4;
            S_ALU_T4:  state_d = S_ALU_T5;
            S_IMM_T3:  state_d = S_IMM_T4;
            S_IMM_T4:  state_d = S_IMM_T5;
            S_MD_T3:   state_d = S_MD_T4;
            S_MD_T4:   state_d = S_MD_T5;
            S_MD_T5:   state_d = S_MD_T6;
            S_BR_T3:   state_d = S_BR_T4;
            S_BR_T4:   state_d = S_BR_T5;
            S_BR_T5:   state_d = S_BR_T6;
            default:   state_d = S_T0;  // last step of every class
        endcase
    end

    // Output decode: everything low by default, each state raises its strobes.
    always_comb begin
        run = 1'b1;
        pc_init_enable = 1'b0; pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0;
        hi_out = 1'b0; lo_out = 1'b0; mdr_out = 1'b0; inport_out = 1'b0;
        c_sign_extended_out = 1'b0; ba_out = 1'b0; r_out = 1'b0;
        mar_enable = 1'b0; z_enable = 1'b0; lo_enable = 1'b0; hi_enable = 1'b0;
        pc_enable = 1'b0; mdr_enable = 1'b0; ir_enable = 1'b0; y_enable = 1'b0;
        outport_enable = 1'b0; inport_enable = 1'b0; con_enable = 1'b0; r_in = 1'b0;
        pc_increment = 1'b0; read = 1'b0; ram_write = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        case (state_q)
            S_RESET:  begin run = 1'b0; pc_init_enable = 1'b1; end
            S_HALTED: run = 1'b0;
            S_T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; end
            S_T1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
            S_LD_T3, S_LDI_T3, S_ST_T3: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
            S_LD_T4, S_LDI_T4, S_ST_T4, S_IMM_T4:
                begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
            S_LD_T5, S_ST_T5: begin zlo_out = 1'b1; mar_enable = 1'b1; end
            S_LD_T6:  begin read = 1'b1; mdr_enable = 1'b1; end
            S_LD_T7:  begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_LDI_T5, S_ALU_T5, S_IMM_T5: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_ST_T6:  begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
            S_ST_T7:  ram_write = 1'b1;
            S_ALU_T3, S_IMM_T3: begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
            S_ALU_T4: begin grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
            S_MD_T3:  begin gra = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
            S_MD_T4:  begin grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
            S_MD_T5:  begin zlo_out = 1'b1; lo_enable = 1'b1; end
            S_MD_T6:  begin zhi_out = 1'b1; hi_enable = 1'b1; end
            S_BR_T3:  begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
            S_BR_T4:  begin pc_out = 1'b1; y_enable = 1'b1; end
            S_BR_T5:  begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
            S_BR_T6:  begin zlo_out = 1'b1; pc_enable = con_ff; end
            S_JR_T3:  begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
            S_IN_T3:  begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_OUT_T3: begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
            S_MFHI_T3: begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_MFLO_T3: begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            default:  run = 1'b0;
        endcase
    end

endmodule
